// File: rtl/tick_timer.sv
// Programmable tick generator: counts enabled cycles up to a loadable terminal
// value and emits a registered one-cycle tick, in periodic or one-shot mode.
module tick_timer #(
    parameter int WIDTH     = 7,
    parameter int COUNT_TO  = 100,
    parameter bit AUTOSTART = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic             mode_i,
    output logic             tick_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] count_o
);

    generate
        if (COUNT_TO < 1 || COUNT_TO > (1 << WIDTH)) begin : g_bad_count_to
            $error("tick_timer: COUNT_TO must lie in 1..2**WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(COUNT_TO - 1);
    localparam state_t           RST_STATE  = AUTOSTART ? RUN : IDLE;

    state_t           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] period_reg;
    logic             mode_reg;
    logic             tick_reg;

    // Control pulses are prioritised load > stop > start > counting, and
    // every one of them clears the count so a shorter period is always safe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= RST_STATE;
            count_reg  <= '0;
            period_reg <= RST_PERIOD;
            mode_reg   <= 1'b0;
            tick_reg   <= 1'b0;
        end else if (load_i) begin
            period_reg <= period_i;
            mode_reg   <= mode_i;
            count_reg  <= '0;
            tick_reg   <= 1'b0;
        end else if (stop_i) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            tick_reg   <= 1'b0;
        end else if (start_i) begin
            state_reg  <= RUN;
            mode_reg   <= mode_i;
            count_reg  <= '0;
            tick_reg   <= 1'b0;
        end else if (state_reg == RUN && en_i) begin
            if (count_reg == period_reg) begin
                count_reg <= '0;
                tick_reg  <= 1'b1;
                if (mode_reg) begin
                    state_reg <= IDLE;
                end
            end else begin
                count_reg <= count_reg + WIDTH'(1);
                tick_reg  <= 1'b0;
            end
        end else begin
            tick_reg <= 1'b0;
        end
    end

    assign tick_o  = tick_reg;
    assign busy_o  = (state_reg == RUN);
    assign count_o = count_reg;

endmodule
